// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared state encoding, keycode geometry and nibble selection for the alarm blocks
package alarm_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        LOCKED  = 1'b1
    } state_e;

    localparam int NUM_DIGITS = 4;
    localparam int DIGIT_W    = 4;
    localparam int KEYCODE_W  = 16;

    function automatic logic [DIGIT_W-1:0] nibble_at(input logic [KEYCODE_W-1:0] kc,
                                                     input logic [1:0]           idx);
        return kc[DIGIT_W*int'(idx) +: DIGIT_W];
    endfunction

endpackage

// File: rtl/lockout_timer.sv
// rtl/lockout_timer.sv - counts the lockout window after start and pulses done on its final cycle
module lockout_timer #(
    parameter int LOCKOUT_CYCLES = 250
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    output logic done
);

    localparam int            CW   = $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(LOCKOUT_CYCLES - 1);

    logic [CW-1:0] count_q, count_d;
    logic          active_q, active_d;

    assign done = active_q && (count_q == LAST);

    always_comb begin
        count_d  = count_q;
        active_d = active_q;
        if (start) begin
            count_d  = '0;
            active_d = 1'b1;
        end else if (active_q) begin
            count_d = count_q + CW'(1);
            if (done) begin
                active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q  <= '0;
            active_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            active_q <= active_d;
        end
    end

endmodule

// File: rtl/keycode_checker.sv
// rtl/keycode_checker.sv - checks entered digits against the stored keycode, grants/denies and locks out
module keycode_checker
    import alarm_pkg::*;
#(
    parameter int MAX_ATTEMPTS   = 3,
    parameter int LOCKOUT_CYCLES = 250
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               write,
    input  logic [DIGIT_W-1:0]                 digit,
    input  logic                               clear,
    input  logic [KEYCODE_W-1:0]               keycode,
    output logic                               granted,
    output logic                               denied,
    output logic                               locked,
    output logic [2:0]                         digit_count,
    output logic [$clog2(MAX_ATTEMPTS+1)-1:0]  fail_count
);

    localparam int FW = $clog2(MAX_ATTEMPTS + 1);

    state_e          state_q;
    logic [2:0]      digit_count_q;
    logic            mismatch_q;
    logic [FW-1:0]   fail_count_q;
    logic            granted_q, denied_q, locked_q;

    logic [DIGIT_W-1:0] nibble;
    logic               mismatch_d;
    logic [FW-1:0]      fail_inc;
    logic               last_digit;
    logic               lock_start;
    logic               timer_done;

    // Each digit is judged against the keycode present on its own write cycle.
    always_comb begin
        nibble     = nibble_at(keycode, digit_count_q[1:0]);
        mismatch_d = mismatch_q | (digit != nibble);
        fail_inc   = fail_count_q + FW'(1);
        last_digit = (state_q == COLLECT) && write && !clear
                     && (digit_count_q == 3'(NUM_DIGITS - 1));
        lock_start = last_digit && mismatch_d && (fail_inc == FW'(MAX_ATTEMPTS));
    end

    lockout_timer #(
        .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
    ) u_lockout_timer (
        .clock (clock),
        .reset (reset),
        .start (lock_start),
        .done  (timer_done)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= COLLECT;
            digit_count_q <= '0;
            mismatch_q    <= 1'b0;
            fail_count_q  <= '0;
            granted_q     <= 1'b0;
            denied_q      <= 1'b0;
            locked_q      <= 1'b0;
        end else begin
            granted_q <= 1'b0;
            denied_q  <= 1'b0;
            case (state_q)
                COLLECT: begin
                    if (clear) begin
                        digit_count_q <= '0;
                        mismatch_q    <= 1'b0;
                    end else if (write) begin
                        if (last_digit) begin
                            digit_count_q <= '0;
                            mismatch_q    <= 1'b0;
                            if (mismatch_d) begin
                                denied_q     <= 1'b1;
                                fail_count_q <= fail_inc;
                                if (lock_start) begin
                                    state_q  <= LOCKED;
                                    locked_q <= 1'b1;
                                end
                            end else begin
                                granted_q    <= 1'b1;
                                fail_count_q <= '0;
                            end
                        end else begin
                            digit_count_q <= digit_count_q + 3'd1;
                            mismatch_q    <= mismatch_d;
                        end
                    end
                end
                LOCKED: begin
                    if (timer_done) begin
                        state_q      <= COLLECT;
                        fail_count_q <= '0;
                        locked_q     <= 1'b0;
                    end
                end
                default: state_q <= COLLECT;
            endcase
        end
    end

    assign granted     = granted_q;
    assign denied      = denied_q;
    assign locked      = locked_q;
    assign digit_count = digit_count_q;
    assign fail_count  = fail_count_q;

endmodule

// File: tb/tb_keycode_checker.sv
// tb/tb_keycode_checker.sv - scoreboard bench for keycode_checker with a queue-based reference model
module tb_keycode_checker;

    localparam int MAX = 3;
    localparam int LC  = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        write = 1'b0;
    logic        clear = 1'b0;
    logic [3:0]  digit = 4'd0;
    logic [15:0] keycode = 16'h4321;
    logic        granted, denied, locked;
    logic [2:0]  digit_count;
    logic [1:0]  fail_count;

    keycode_checker #(
        .MAX_ATTEMPTS   (MAX),
        .LOCKOUT_CYCLES (LC)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .write       (write),
        .digit       (digit),
        .clear       (clear),
        .keycode     (keycode),
        .granted     (granted),
        .denied      (denied),
        .locked      (locked),
        .digit_count (digit_count),
        .fail_count  (fail_count)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int due;
        bit g;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    // Reference model: digits entered so far, with the keycode nibble seen at each write.
    int ent_d[$];
    int ent_k[$];
    int fails     = 0;
    int lock_left = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (granted && denied) chk("pulse_exclusive", 1, 0);
            if (granted || denied) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pulse", granted ? 1 : 2, 0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("pulse_cycle", cyc, mon_e.due);
                    chk("pulse_kind_granted", int'(granted), int'(mon_e.g));
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                chk("missing_pulse", 0, 1);
                void'(sb.pop_front());
            end
        end
    end

    task automatic model_step(input bit w, input bit c, input int d, input logic [15:0] kc);
        bit ok;
        if (lock_left > 0) begin
            lock_left--;
            if (lock_left == 0) fails = 0;
        end else if (c) begin
            ent_d.delete();
            ent_k.delete();
        end else if (w) begin
            ent_d.push_back(d);
            ent_k.push_back(int'((kc >> (4 * ent_k.size())) & 16'hF));
            if (ent_d.size() == 4) begin
                ok = 1'b1;
                for (int i = 0; i < 4; i++) if (ent_d[i] != ent_k[i]) ok = 1'b0;
                sb.push_back('{cyc + 1, ok});
                if (ok) begin
                    fails = 0;
                end else begin
                    fails++;
                    if (fails == MAX) lock_left = LC;
                end
                ent_d.delete();
                ent_k.delete();
            end
        end
    endtask

    task automatic cycle(input bit w, input bit c, input logic [3:0] d, input logic [15:0] kc);
        @(negedge clock);
        write   = w;
        clear   = c;
        digit   = d;
        keycode = kc;
        model_step(w, c, int'(d), kc);
        @(posedge clock);
        #1;
        chk("locked", int'(locked), int'(lock_left > 0));
        chk("digit_count", int'(digit_count), ent_d.size());
        chk("fail_count", int'(fail_count), fails);
    endtask

    task automatic entry(input logic [15:0] kc, input logic [15:0] ds);
        logic [15:0] dv;
        dv = ds;
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, dv[4*i +: 4], kc);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 4'd0, keycode);
    endtask

    task automatic do_reset();
        @(negedge clock);
        write = 1'b0;
        clear = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("rst_locked", int'(locked), 0);
        chk("rst_digit_count", int'(digit_count), 0);
        chk("rst_fail_count", int'(fail_count), 0);
        ent_d.delete();
        ent_k.delete();
        fails     = 0;
        lock_left = 0;
        sb.delete();
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        #2;
        chk("init_granted", int'(granted), 0);
        chk("init_denied", int'(denied), 0);
        chk("init_locked", int'(locked), 0);
        chk("init_digit_count", int'(digit_count), 0);
        chk("init_fail_count", int'(fail_count), 0);
        @(negedge clock);
        reset = 1'b0;

        entry(16'h4321, 16'h4321);
        entry(16'h4321, 16'h5321);
        idle(1);

        entry(16'h4321, 16'h0000);
        entry(16'h4321, 16'h4320);
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 4'($urandom_range(0, 15)), 16'h4321);
        entry(16'h4321, 16'h4321);

        entry(16'h4321, 16'h1111);
        entry(16'h4321, 16'h4322);
        entry(16'h4321, 16'h4321);

        entry(16'h4321, 16'h4331);
        cycle(1'b1, 1'b0, 4'd9, 16'h4321);
        cycle(1'b1, 1'b0, 4'd9, 16'h4321);
        cycle(1'b0, 1'b1, 4'd0, 16'h4321);
        entry(16'h4321, 16'h4321);
        cycle(1'b1, 1'b1, 4'd1, 16'h4321);
        entry(16'h4321, 16'h4321);

        entry(16'hA5C3, 16'h0000);
        entry(16'hA5C3, 16'h0001);
        entry(16'hA5C3, 16'h0002);
        idle(2);
        do_reset();
        entry(16'hA5C3, 16'hA5C3);

        entry(16'h4321, 16'h9999);
        cycle(1'b1, 1'b0, 4'd1, 16'h4321);
        cycle(1'b1, 1'b0, 4'd2, 16'h4321);
        do_reset();
        entry(16'h4321, 16'h4321);

        for (int n = 0; n < 400; n++) begin
            logic [15:0] kc;
            logic [3:0]  d;
            bit          w, c;
            kc = keycode;
            if ($urandom_range(0, 19) == 0) kc = 16'($urandom);
            w = ($urandom_range(0, 9) < 6);
            c = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 1) == 1) d = 4'((kc >> (4 * ent_d.size())) & 16'hF);
            else d = 4'($urandom_range(0, 15));
            cycle(w, c, d, kc);
        end
        idle(3);
        chk("scoreboard_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
